// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction-cache line refill responder: reads a 64-byte line from byte-wide RAM into a 512-bit row
// Optional MEMCTRL_ADDR_WRAP_EN: clears mem_a above ADDR_W so reads wrap inside 2^ADDR_W bytes.
module icache_refill #(
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic [31:0]  missing_PC,
    input  logic         missing_config,
    output logic [511:0] return_row,
    output logic         return_config,
    input  logic [7:0]   mem_din,
    output logic [7:0]   mem_dout,
    output logic [31:0]  mem_a,
    output logic         mem_wr
);

`ifdef MEMCTRL_ADDR_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [31:0] ADDR_MASK = WRAP_EN ? 32'((64'd1 << ADDR_W) - 64'd1) : 32'hFFFF_FFFF;
    localparam logic [6:0]  LAST_IDX  = 7'(LINE_BYTES - 1);
    localparam logic [6:0]  LINE_CNT  = 7'(LINE_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [25:0]    base_q, base_d;
    logic [31:0]    mem_a_q, mem_a_d;
    logic [6:0]     issue_cnt_q, issue_cnt_d;
    logic [6:0]     recv_cnt_q, recv_cnt_d;
    logic [1:0]     pipe_v_q, pipe_v_d;
    logic [511:0]   row_q, row_d;
    logic           ret_q, ret_d;
    logic [8:0]     byte_lsb;
    logic           unused_pc_bits;

    assign unused_pc_bits = ^missing_PC[5:0];
    assign byte_lsb       = {recv_cnt_q[5:0], 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_a_q     <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pipe_v_q    <= 2'b00;
            row_q       <= '0;
            ret_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            mem_a_q     <= mem_a_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pipe_v_q    <= pipe_v_d;
            row_q       <= row_d;
            ret_q       <= ret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        mem_a_d     = mem_a_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pipe_v_d    = pipe_v_q;
        row_d       = row_q;
        ret_d       = ret_q;

        if (!rdy) begin
            // A pause drops every in-flight read; they are re-issued from the next missing byte.
            pipe_v_d    = 2'b00;
            issue_cnt_d = recv_cnt_q;
        end else begin
            case (state_q)
                IDLE: begin
                    ret_d = 1'b0;
                    if (missing_config) begin
                        base_d      = missing_PC[31:6];
                        mem_a_d     = {missing_PC[31:6], 6'b0} & ADDR_MASK;
                        issue_cnt_d = 7'd1;
                        recv_cnt_d  = 7'd0;
                        pipe_v_d    = 2'b01;
                        state_d     = READ;
                    end
                end
                READ: begin
                    if (issue_cnt_q < LINE_CNT) begin
                        mem_a_d     = {base_q, issue_cnt_q[5:0]} & ADDR_MASK;
                        issue_cnt_d = issue_cnt_q + 7'd1;
                        pipe_v_d    = {pipe_v_q[0], 1'b1};
                    end else begin
                        pipe_v_d    = {pipe_v_q[0], 1'b0};
                    end
                    // pipe_v[1] marks the byte addressed two edges ago as present on mem_din.
                    if (pipe_v_q[1]) begin
                        row_d[byte_lsb +: 8] = mem_din;
                        recv_cnt_d           = recv_cnt_q + 7'd1;
                        if (recv_cnt_q == LAST_IDX) begin
                            state_d = DONE;
                            ret_d   = 1'b1;
                        end
                    end
                end
                DONE: begin
                    ret_d   = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign return_row    = row_q;
    assign return_config = ret_q;
    assign mem_a         = mem_a_q;
    assign mem_dout      = 8'h00;
    assign mem_wr        = 1'b0;

endmodule
